vending_machine_multi: RTL and testbench
========================================

Name: vending_machine_multi

Overview:
Parametrised successor to the team's single-product vending controller.
- Supports NUM_DRINKS products with per-product price and stock counters.
- Validates coins, caps credit, and supports cancel/refund.
- Returns change as a multi-cycle stream of coins (greedy 50/10/5/1) instead of one lump value.
- Sits between the coin-acceptor front end and the dispenser/coin-hopper drivers.

Parameters:
- NUM_DRINKS, 4, number of products; product IDs 1..NUM_DRINKS, ID 0 = none.
- MONEY_W, 8, width of coin, credit and price values.
- SEL_W, 3, width of product ID; must satisfy 2^SEL_W > NUM_DRINKS.
- PRICE_LIST, {8'd25,8'd20,8'd15,8'd10}, flattened prices; product k uses bits [k*MONEY_W-1 -: MONEY_W], so the defaults are Tea=10, Coke=15, Coffee=20, Milk=25.
- STOCK_W, 4, width of each stock counter.
- STOCK_INIT, 4, stock loaded per product at reset/restock.
- MAX_CREDIT, 200, upper bound on total_money.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coin_valid  in  1  coin strobe, one cycle per coin.
- coin  in  MONEY_W  coin value; legal values are 1, 5, 10, 50.
- drink_choose  in  SEL_W  product request; level-sampled, 0 = none.
- cancel  in  1  refund request.
- restock  in  1  reload all stock counters.
- total_money  out  MONEY_W  current credit.
- state  out  3  FSM state.
- coin_reject  out  1  one-cycle pulse: coin refused.
- drink_out  out  SEL_W  dispensed product ID.
- drink_valid  out  1  one-cycle dispense pulse.
- change_coin  out  MONEY_W  change coin denomination.
- change_valid  out  1  change_coin valid this cycle.
- sold_out  out  NUM_DRINKS  bit k-1 set when stock of product k == 0.

Behaviour:
- Reset (sync, high) → state=IDLE, total_money=0, all stocks=STOCK_INIT, all pulse outputs 0, drink_out=0, change_coin=0. Reset asserted mid-vend or mid-change aborts immediately; pending change is discarded.
- States:
  - IDLE=0
  - ACCUM=1
  - DISPENSE=2
  - CHANGE=3
  - Encodings 4-7 → IDLE next cycle.
- Coin acceptance (IDLE, ACCUM only):
  - Accepted when coin_valid and coin ∈ {1,5,10,50} and total_money+coin ≤ MAX_CREDIT.
  - Accepted coin → total_money += coin on the next edge.
  - Otherwise coin_reject=1 for one cycle and total_money is unchanged.
  - Any coin_valid in DISPENSE or CHANGE is rejected.
  - Sum is computed at MONEY_W+1 bits, so no wrap.
- IDLE: accepted coin → ACCUM. restock=1 → all stocks=STOCK_INIT (restock ignored in other states).
- ACCUM, priority high→low:
  - cancel=1 → CHANGE, refunding full credit; any coin that cycle is rejected.
  - drink_choose=k, 1≤k≤NUM_DRINKS, total_money ≥ price[k], stock[k]>0 → DISPENSE. On that edge: total_money -= price[k], stock[k] -= 1, latch k. The comparison uses pre-coin credit; a coin arriving in the same cycle is still accepted and added.
  - Otherwise remain in ACCUM; out-of-range or unaffordable selection is ignored.
- DISPENSE: exactly one cycle. drink_valid=1, drink_out=k. Next state is CHANGE if total_money>0, else IDLE.
- CHANGE:
  - Each cycle: change_valid=1, change_coin = largest of {50,10,5,1} ≤ total_money, and total_money -= change_coin.
  - When the remainder reaches 0 → IDLE.
  - Entered with total_money=0 (cancel with no credit) → no coin emitted, IDLE next cycle.
  - Inputs other than reset are ignored.
- drink_out holds its value until the next DISPENSE; it is cleared only by reset.
- sold_out is combinational from the stock counters. Stock never underflows.

Optional Feature:
- Macro: VM_MULTI_VEND_EN.
- Defined: DISPENSE with remaining credit >0 returns to ACCUM (credit retained for further purchases); change is returned only via cancel.
- Undefined: DISPENSE always goes to CHANGE/IDLE as above.

Test Plan:
- Reset, coin 10 → ACCUM, total 10; drink_choose=1 → DISPENSE, drink_valid with drink_out=1 → IDLE, no change_valid, stock[1]=3.
- Coins 50, 5, 1, 1 (total 57), choose 2 (Coke 15) → remainder 42 → change stream 10,10,10,10,1,1 over 6 consecutive cycles → IDLE, total 0.
- Coin 7 and coin 50 at total_money=180 → coin_reject pulse each, total unchanged at 180; coin in CHANGE state → rejected.
- Coins 10, 5 → cancel → change 10, 5 → IDLE; choose 4 with total 20 → no dispense, stays ACCUM.
- Buy product 3 four times → sold_out[2]=1, fifth request ignored; restock in IDLE → stock 4, sold_out[2]=0.
- Reset asserted during the CHANGE stream → next cycle IDLE, total 0, change_valid 0. With VM_MULTI_VEND_EN: total 30, buy Tea → ACCUM with total 20.

Source files
------------

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-product vending controller with greedy change stream; option macro VM_MULTI_VEND_EN
module vending_machine_multi #(
    parameter int                          NUM_DRINKS = 4,
    parameter int                          MONEY_W    = 8,
    parameter int                          SEL_W      = 3,
    parameter logic [NUM_DRINKS*MONEY_W-1:0] PRICE_LIST = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                          STOCK_W    = 4,
    parameter int                          STOCK_INIT = 4,
    parameter int                          MAX_CREDIT = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  coin_valid,
    input  logic [MONEY_W-1:0]    coin,
    input  logic [SEL_W-1:0]      drink_choose,
    input  logic                  cancel,
    input  logic                  restock,
    output logic [MONEY_W-1:0]    total_money,
    output logic [2:0]            state,
    output logic                  coin_reject,
    output logic [SEL_W-1:0]      drink_out,
    output logic                  drink_valid,
    output logic [MONEY_W-1:0]    change_coin,
    output logic                  change_valid,
    output logic [NUM_DRINKS-1:0] sold_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACCUM    = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3
    } state_e;

    state_e               state_q, state_d;
    logic [MONEY_W-1:0]   total_q, total_d;
    logic [SEL_W-1:0]     drink_q, drink_d;
    logic                 coin_reject_q, coin_reject_d;
    logic [STOCK_W-1:0]   stock_q [NUM_DRINKS];
    logic [STOCK_W-1:0]   stock_d [NUM_DRINKS];

    logic [MONEY_W:0]     coin_sum;
    logic                 coin_legal;
    logic                 coin_ok;
    logic                 sel_hit;
    logic [MONEY_W-1:0]   sel_price;
    logic                 sel_in_stock;
    logic                 buy;
    logic                 restock_all;
    logic [MONEY_W-1:0]   change_amt;

    // Coin check: legal denomination and credit cap, summed one bit wider so it cannot wrap
    always_comb begin
        coin_sum   = {1'b0, total_q} + {1'b0, coin};
        coin_legal = (coin == MONEY_W'(1))  || (coin == MONEY_W'(5)) ||
                     (coin == MONEY_W'(10)) || (coin == MONEY_W'(50));
        coin_ok    = coin_valid && coin_legal && (coin_sum <= (MONEY_W+1)'(MAX_CREDIT));
    end

    // Look up price and stock of the requested product; ID 0 and IDs above NUM_DRINKS never hit
    always_comb begin
        sel_hit      = 1'b0;
        sel_price    = '0;
        sel_in_stock = 1'b0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (drink_choose == SEL_W'(i + 1)) begin
                sel_hit      = 1'b1;
                sel_price    = PRICE_LIST[i*MONEY_W +: MONEY_W];
                sel_in_stock = (stock_q[i] != '0);
            end
        end
    end

    // Largest hopper denomination not exceeding the remaining credit
    always_comb begin
        if (total_q >= MONEY_W'(50)) begin
            change_amt = MONEY_W'(50);
        end else if (total_q >= MONEY_W'(10)) begin
            change_amt = MONEY_W'(10);
        end else if (total_q >= MONEY_W'(5)) begin
            change_amt = MONEY_W'(5);
        end else if (total_q >= MONEY_W'(1)) begin
            change_amt = MONEY_W'(1);
        end else begin
            change_amt = '0;
        end
    end

    // Next-state, credit, product latch and reject decision
    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        drink_d       = drink_q;
        coin_reject_d = 1'b0;
        buy           = 1'b0;
        restock_all   = 1'b0;
        case (state_q)
            S_IDLE: begin
                restock_all = restock;
                if (coin_valid) begin
                    if (coin_ok) begin
                        total_d = coin_sum[MONEY_W-1:0];
                        state_d = S_ACCUM;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (cancel) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = coin_valid;
                end else begin
                    // Affordability uses the credit held before any coin arriving this cycle
                    if (sel_hit && (total_q >= sel_price) && sel_in_stock) begin
                        buy     = 1'b1;
                        state_d = S_DISPENSE;
                        drink_d = drink_choose;
                    end
                    coin_reject_d = coin_valid && !coin_ok;
                    total_d = total_q - (buy ? sel_price : '0) + (coin_ok ? coin : '0);
                end
            end
            S_DISPENSE: begin
                coin_reject_d = coin_valid;
                if (total_q == '0) begin
                    state_d = S_IDLE;
                end else begin
`ifdef VM_MULTI_VEND_EN
                    state_d = S_ACCUM;
`else
                    state_d = S_CHANGE;
`endif
                end
            end
            S_CHANGE: begin
                coin_reject_d = coin_valid;
                total_d       = total_q - change_amt;
                if (total_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stock counters: full reload on restock, single decrement on a purchase
    always_comb begin
        for (int i = 0; i < NUM_DRINKS; i++) begin
            stock_d[i] = stock_q[i];
            if (restock_all) begin
                stock_d[i] = STOCK_W'(STOCK_INIT);
            end else if (buy && (drink_choose == SEL_W'(i + 1))) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
        end
    end

    // State and datapath registers; reset abandons any vend or change in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            total_q       <= '0;
            drink_q       <= '0;
            coin_reject_q <= 1'b0;
            for (int i = 0; i < NUM_DRINKS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            drink_q       <= drink_d;
            coin_reject_q <= coin_reject_d;
            for (int i = 0; i < NUM_DRINKS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign total_money  = total_q;
    assign state        = state_q;
    assign coin_reject  = coin_reject_q;
    assign drink_out    = drink_q;
    assign drink_valid  = (state_q == S_DISPENSE);
    assign change_valid = (state_q == S_CHANGE) && (total_q != '0);
    assign change_coin  = change_valid ? change_amt : '0;

    for (genvar g = 0; g < NUM_DRINKS; g++) begin : g_sold_out
        assign sold_out[g] = (stock_q[g] == '0);
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb/tb_vending_machine_multi.sv - scoreboard bench for vending_machine_multi with transaction-level model
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [7:0] coin;
    logic [2:0] drink_choose;
    logic       cancel;
    logic       restock;
    logic [7:0] total_money;
    logic [2:0] state;
    logic       coin_reject;
    logic [2:0] drink_out;
    logic       drink_valid;
    logic [7:0] change_coin;
    logic       change_valid;
    logic [3:0] sold_out;

    vending_machine_multi dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin        (coin),
        .drink_choose(drink_choose),
        .cancel      (cancel),
        .restock     (restock),
        .total_money (total_money),
        .state       (state),
        .coin_reject (coin_reject),
        .drink_out   (drink_out),
        .drink_valid (drink_valid),
        .change_coin (change_coin),
        .change_valid(change_valid),
        .sold_out    (sold_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int credit;
    int stock [1:4];
    int last_drink;

    // scoreboard queues
    int rej_q[$];
    int dk_q[$];
    int dt_q[$];
    int ck_q[$];
    int ct_q[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int price(input int k);
        case (k)
            1: return 10;
            2: return 15;
            3: return 20;
            default: return 25;
        endcase
    endfunction

    function automatic bit legal(input int c);
        return (c == 1) || (c == 5) || (c == 10) || (c == 50);
    endfunction

    // refund the whole credit using the fewest coins from {50,10,5,1}
    task automatic push_refund();
        int c;
        while (credit > 0) begin
            c = (credit >= 50) ? 50 : (credit >= 10) ? 10 : (credit >= 5) ? 5 : 1;
            ck_q.push_back(c);
            ct_q.push_back(credit);
            credit -= c;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        int n = 0;
        while (!(state == 3'd0 || state == 3'd1) && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) chk("settle_timeout", 1, 0);
    endtask

    task automatic do_coin(input int c);
        if (legal(c) && credit + c <= 200) credit += c;
        else rej_q.push_back(c);
        coin_valid = 1'b1;
        coin = 8'(c);
        step();
        coin_valid = 1'b0;
        coin = '0;
        settle();
    endtask

    task automatic do_select(input int k, input int c);
        int pre = credit;
        bit bought = (k >= 1) && (k <= 4) && (pre > 0) && (pre >= price(k)) && (stock[(k >= 1 && k <= 4) ? k : 1] > 0);
        bit ok = (c != 0) && legal(c) && (pre + c <= 200);
        if (c != 0 && !ok) rej_q.push_back(c);
        if (bought) begin
            credit = pre - price(k) + (ok ? c : 0);
            stock[k]--;
            last_drink = k;
            dk_q.push_back(k);
            dt_q.push_back(credit);
`ifndef VM_MULTI_VEND_EN
            push_refund();
`endif
        end else if (ok) begin
            credit += c;
        end
        drink_choose = 3'(k);
        coin_valid = (c != 0);
        coin = 8'(c);
        step();
        drink_choose = '0;
        coin_valid = 1'b0;
        coin = '0;
        settle();
    endtask

    task automatic do_cancel(input int c);
        if (credit > 0) begin
            if (c != 0) rej_q.push_back(c);
            push_refund();
        end else if (c != 0) begin
            if (legal(c)) credit += c;
            else rej_q.push_back(c);
        end
        cancel = 1'b1;
        coin_valid = (c != 0);
        coin = 8'(c);
        step();
        cancel = 1'b0;
        coin_valid = 1'b0;
        coin = '0;
        settle();
    endtask

    task automatic do_restock();
        if (credit == 0) for (int i = 1; i <= 4; i++) stock[i] = 4;
        restock = 1'b1;
        step();
        restock = 1'b0;
        settle();
    endtask

    task automatic check_status(input string tag);
        int exp_so = 0;
        for (int i = 1; i <= 4; i++) if (stock[i] == 0) exp_so |= (1 << (i - 1));
        chk({tag, "_total"}, int'(total_money), credit);
        chk({tag, "_state"}, int'(state), (credit > 0) ? 1 : 0);
        chk({tag, "_sold_out"}, int'(sold_out), exp_so);
        chk({tag, "_drink_out"}, int'(drink_out), last_drink);
    endtask

    // monitor: every DUT output event is matched against the next expected event of its kind
    always @(negedge clk) begin
        int k, t;
        if (coin_reject === 1'b1) begin
            chk("reject_expected", (rej_q.size() > 0) ? 1 : 0, 1);
            if (rej_q.size() > 0) k = rej_q.pop_front();
        end
        if (drink_valid === 1'b1) begin
            if (dk_q.size() == 0) begin
                chk("drink_unexpected", int'(drink_out), 0);
            end else begin
                k = dk_q.pop_front();
                t = dt_q.pop_front();
                chk("drink_out", int'(drink_out), k);
                chk("drink_total", int'(total_money), t);
            end
        end
        if (change_valid === 1'b1) begin
            if (ck_q.size() == 0) begin
                chk("change_unexpected", int'(change_coin), 0);
            end else begin
                k = ck_q.pop_front();
                t = ct_q.pop_front();
                chk("change_coin", int'(change_coin), k);
                chk("change_total", int'(total_money), t);
            end
        end
    end

    initial begin
        int op, k, c;
        int coin_tab [12] = '{1, 5, 10, 50, 50, 50, 0, 2, 7, 25, 100, 255};
        reset = 1'b1;
        coin_valid = 1'b0;
        coin = '0;
        drink_choose = '0;
        cancel = 1'b0;
        restock = 1'b0;
        credit = 0;
        last_drink = 0;
        for (int i = 1; i <= 4; i++) stock[i] = 4;
        step();
        step();
        reset = 1'b0;
        check_status("reset");
        chk("reset_change_valid", int'(change_valid), 0);
        chk("reset_drink_valid", int'(drink_valid), 0);
        chk("reset_coin_reject", int'(coin_reject), 0);

        // single tea, exact money
        do_coin(10);
        check_status("t1_accum");
        do_select(1, 0);
        check_status("t1_done");

        // coke from 57 -> 42 change
        do_coin(50); do_coin(5); do_coin(1); do_coin(1);
        do_select(2, 0);
        check_status("t2_done");

        // credit cap and illegal coins
        do_coin(50); do_coin(50); do_coin(50); do_coin(10); do_coin(10); do_coin(10);
        do_coin(7);
        do_coin(50);
        check_status("t3_180");
        do_coin(10); do_coin(10);
        check_status("t3_200");
        do_coin(1);
        do_cancel(0);
        check_status("t3_done");

        // cancel, coin during change stream, coin with cancel
        do_coin(10); do_coin(5);
        push_refund();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        rej_q.push_back(10);
        coin_valid = 1'b1;
        coin = 8'd10;
        step();
        coin_valid = 1'b0;
        coin = '0;
        settle();
        check_status("t4_cancel");
        do_coin(10); do_coin(5);
        do_cancel(5);
        do_coin(10); do_coin(10);
        do_select(4, 0);
        check_status("t4_unaffordable");
        do_cancel(0);
        do_coin(10);
        do_select(2, 5);
        check_status("t4_precoin");
        do_select(2, 0);
        do_coin(50);
        do_select(5, 0);
        do_select(7, 0);
        check_status("t4_out_of_range");
        do_cancel(0);

        // sell out product 3, then restock
        for (int i = 0; i < 4; i++) begin
            do_coin(10); do_coin(10);
            do_select(3, 0);
        end
        check_status("t5_sold_out");
        do_coin(10); do_coin(10);
        do_select(3, 0);
        check_status("t5_fifth");
        do_cancel(0);
        do_restock();
        check_status("t5_restock");

        // reset during the change stream: only the first coin escapes
        do_coin(50); do_coin(5); do_coin(1); do_coin(1);
        ck_q.push_back(50);
        ct_q.push_back(57);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        credit = 0;
        last_drink = 0;
        for (int i = 1; i <= 4; i++) stock[i] = 4;
        chk("t6_change_valid", int'(change_valid), 0);
        check_status("t6_reset");

`ifdef VM_MULTI_VEND_EN
        do_coin(10); do_coin(10); do_coin(10);
        do_select(1, 0);
        check_status("mv_retain");
        do_cancel(0);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                do_coin(coin_tab[$urandom_range(0, 11)]);
            end else if (op <= 7) begin
                k = $urandom_range(0, 7);
                c = ($urandom_range(0, 3) == 0) ? coin_tab[$urandom_range(0, 5)] : 0;
                do_select(k, c);
            end else if (op == 8) begin
                c = (credit > 0 && $urandom_range(0, 1) == 1) ? coin_tab[$urandom_range(0, 11)] : 0;
                do_cancel(c);
            end else begin
                do_restock();
            end
            check_status("rand");
        end

        settle();
        step();
        step();
        chk("left_rejects", rej_q.size(), 0);
        chk("left_drinks", dk_q.size(), 0);
        chk("left_changes", ck_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
